// File: rtl/mau_dot_sequencer.sv
// mau_dot_sequencer: walks a VRAM operand vector two elements per cycle and times the MAU multiply/accumulate
//   clk, reset (async, active high); start, base_addr, length request a dot product of length pairs
//   bus_gnt: X operands valid; busy, done, clr_acc: run status; cea/ceb, ada/adb: VRAM read ports
//   bus_req, set_mults, set_acc: X operand request and multiplier/accumulator load strobes
module mau_dot_sequencer #(
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   input  logic              bus_gnt,
   output logic              busy,
   output logic              done,
   output logic              clr_acc,
   output logic              cea,
   output logic              ceb,
   output logic [ADDR_W-1:0] ada,
   output logic [ADDR_W-1:0] adb,
   output logic              bus_req,
   output logic              set_mults,
   output logic              set_acc
);
   typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, DONE} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] base, ada_q, adb_q;
   logic [LEN_W-1:0] len, k;
   logic v1, v2, adv, issue;
   // Read data waiting on the bus grant is the only thing that can stall the pipeline.
   assign adv = ~v1 | bus_gnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx  = state;
      busy      = state != IDLE;
      done      = state == DONE;
      clr_acc   = state == LOAD;
      issue     = (state == ISSUE) & adv;
      cea       = issue;
      ceb       = issue;
      ada       = state == ISSUE ? base + ADDR_W'({k, 1'b0}) : ada_q;
      adb       = state == ISSUE ? base + ADDR_W'({k, 1'b1}) : adb_q;
      bus_req   = v1;
      set_mults = v1 & bus_gnt;
      set_acc   = v2 & adv;
      case (state)
         IDLE:    state_nx = start ? LOAD : IDLE;
         LOAD:    state_nx = len != '0 ? ISSUE : DONE;
         ISSUE:   state_nx = issue && k == len - LEN_W'(1) ? DRAIN : ISSUE;
         // With v1 clear the last multiplier result moves into the accumulator this cycle.
         DRAIN:   state_nx = v1 ? DRAIN : DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         base  <= '0;
         len   <= '0;
         k     <= '0;
         v1    <= 1'b0;
         v2    <= 1'b0;
         ada_q <= '0;
         adb_q <= '0;
      end else begin
         if (state == IDLE && start) begin
            base <= base_addr;
            len  <= length;
         end
         if (state == LOAD) k <= '0;
         else if (issue) k <= k + LEN_W'(1);
         if (adv) begin
            v1 <= issue;
            v2 <= v1;
         end
         if (state == ISSUE) begin
            ada_q <= ada;
            adb_q <= adb;
         end
      end
endmodule

// File: tb/tb_mau_dot_sequencer.sv
// tb_mau_dot_sequencer: directed runs checked against a pair-counting model plus literal timing expectations
module tb_mau_dot_sequencer;
   logic clk, reset, start, bus_gnt;
   logic [9:0] base_addr, ada, adb;
   logic [8:0] length;
   logic busy, done, clr_acc, cea, ceb, bus_req, set_mults, set_acc;
   int errors = 0, checks = 0, cur = 0;
   int ph = 0, mb = 0, ml = 0, iss = 0, mul = 0, acc = 0, la = 0, lb = 0;
   logic [63:0] h_busy, h_done, h_clr, h_cea, h_br, h_sm, h_sa;
   logic [9:0] h_ada [0:63];
   logic [9:0] h_adb [0:63];
   mau_dot_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
      .bus_gnt(bus_gnt), .busy(busy), .done(done), .clr_acc(clr_acc), .cea(cea), .ceb(ceb),
      .ada(ada), .adb(adb), .bus_req(bus_req), .set_mults(set_mults), .set_acc(set_acc)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cur, act, exp);
      end
   endtask
   // Model: counts pairs issued, multiplied and accumulated; pipeline occupancy follows from the differences.
   always @(negedge clk) begin
      bit pr, pm, adv_e, isg, ecea, esm, esa;
      int ea, eb;
      if (reset) begin
         ph = 0; iss = 0; mul = 0; acc = 0; la = 0; lb = 0;
         chk("reset_outputs", {8'(0), busy, done, clr_acc, cea, ceb, bus_req, set_mults, set_acc, ada, adb}, 0);
      end else begin
         pr    = ph == 2 && iss > mul;
         pm    = ph == 2 && mul > acc;
         adv_e = !pr || bus_gnt;
         isg   = ph == 2 && iss < ml;
         ecea  = isg && adv_e;
         ea    = isg ? (mb + 2 * iss) % 1024 : la;
         eb    = isg ? (mb + 2 * iss + 1) % 1024 : lb;
         esm   = pr && bus_gnt;
         esa   = pm && adv_e;
         chk("busy", 32'(busy), 32'(ph != 0));
         chk("done", 32'(done), 32'(ph == 3));
         chk("clr_acc", 32'(clr_acc), 32'(ph == 1));
         chk("cea", 32'(cea), 32'(ecea));
         chk("ceb", 32'(ceb), 32'(ecea));
         chk("ada", 32'(ada), ea);
         chk("adb", 32'(adb), eb);
         chk("bus_req", 32'(bus_req), 32'(pr));
         chk("set_mults", 32'(set_mults), 32'(esm));
         chk("set_acc", 32'(set_acc), 32'(esa));
         if (isg) begin la = ea; lb = eb; end
         iss += int'(ecea);
         mul += int'(esm);
         acc += int'(esa);
         case (ph)
            0: if (start) begin ph = 1; mb = int'(base_addr); ml = int'(length); end
            1: begin iss = 0; mul = 0; acc = 0; ph = ml == 0 ? 3 : 2; end
            2: if (acc == ml) ph = 3;
            default: ph = 0;
         endcase
      end
      if (cur == 0) begin
         h_busy = '0; h_done = '0; h_clr = '0; h_cea = '0; h_br = '0; h_sm = '0; h_sa = '0;
      end
      h_busy[cur] = busy; h_done[cur] = done; h_clr[cur] = clr_acc; h_cea[cur] = cea;
      h_br[cur] = bus_req; h_sm[cur] = set_mults; h_sa[cur] = set_acc;
      h_ada[cur] = ada; h_adb[cur] = adb;
   end
   // sa..sb: cycles with bus_gnt low; rc: cycle of a mid-run reset; sc: cycle of a start pulse while busy
   task automatic run(input logic [9:0] b, input logic [8:0] l, input int sa, input int sb, input int rc, input int sc);
      cur = 0; base_addr = b; length = l; start = 1; bus_gnt = 1;
      @(posedge clk); #1;
      start = 0;
      for (int n = 1; n <= 20; n++) begin
         cur = n;
         bus_gnt = (n >= sa && n <= sb) ? 1'b0 : 1'b1;
         start = n == sc;
         if (n == sc) begin base_addr = ~b; length = l + 9'd5; end
         if (n == rc) begin
            #2 reset = 1;
            #1 chk("async_reset", {8'(0), busy, done, clr_acc, cea, ceb, bus_req, set_mults, set_acc, ada, adb}, 0);
            @(posedge clk); #1;
            reset = 0;
            break;
         end
         @(posedge clk); #1;
      end
      start = 0; bus_gnt = 1;
   endtask
   initial begin
      reset = 1; start = 0; bus_gnt = 1; base_addr = '0; length = '0;
      @(posedge clk); #1;
      reset = 0;
      chk("idle_after_reset", {21'(0), busy, ada}, 0);
      run(10'h010, 9'd4, 0, -1, 0, 0);
      chk("t1_cea", h_cea[31:0], 32'h3C);
      chk("t1_ada2", 32'(h_ada[2]), 32'h010);
      chk("t1_adb5", 32'(h_adb[5]), 32'h017);
      chk("t1_set_acc", h_sa[31:0], 32'hF0);
      chk("t1_done", h_done[31:0], 32'h100);
      chk("t1_clr_acc", h_clr[31:0], 32'h2);
      chk("t1_busy", h_busy[31:0], 32'h1FE);
      run(10'h020, 9'd3, 3, 4, 0, 0);
      chk("t2_cea", h_cea[31:0], 32'h64);
      chk("t2_set_mults", h_sm[31:0], 32'hE0);
      chk("t2_bus_req", h_br[31:0], 32'hF8);
      chk("t2_set_acc", h_sa[31:0], 32'h1C0);
      chk("t2_done", h_done[31:0], 32'h200);
      run(10'h155, 9'd0, 0, -1, 0, 0);
      chk("t3_busy", h_busy[31:0], 32'h6);
      chk("t3_done", h_done[31:0], 32'h4);
      chk("t3_no_issue", {h_cea[31:0] | h_sm[31:0] | h_sa[31:0]}, 0);
      run(10'h3FE, 9'd2, 0, -1, 0, 0);
      chk("t4_ada2", 32'(h_ada[2]), 32'h3FE);
      chk("t4_adb2", 32'(h_adb[2]), 32'h3FF);
      chk("t4_ada3", 32'(h_ada[3]), 32'h000);
      chk("t4_adb3", 32'(h_adb[3]), 32'h001);
      run(10'h100, 9'd8, 0, -1, 5, 0);
      chk("t5_no_done", h_done[31:0], 0);
      run(10'h005, 9'd1, 0, -1, 0, 0);
      chk("t5_clean_done", h_done[31:0], 32'h20);
      chk("t5_clean_cea", h_cea[31:0], 32'h4);
      chk("t5_clean_ada", 32'(h_ada[2]), 32'h005);
      run(10'h040, 9'd2, 0, -1, 0, 3);
      chk("t6_done", h_done[31:0], 32'h40);
      chk("t6_cea", h_cea[31:0], 32'hC);
      chk("t6_ada3", 32'(h_ada[3]), 32'h042);
      chk("t6_adb3", 32'(h_adb[3]), 32'h043);
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
